key_expand_seq: RTL and testbench
=================================

Name: key_expand_seq

Overview:
Iterative AES-128 key-schedule engine that consumes the round-constant sequence and produces one 128-bit round key per accepted transfer. A cipher key is loaded on `start`. Round keys 0..ROUNDS are then streamed to the round datapath over a valid/ready handshake. The block sits directly downstream of round-constant generation and upstream of the AddRoundKey stage.

Parameters:
- ROUNDS, 10, index of the last round key emitted. Legal range 1..10; values outside are unsupported.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load `key_in` and begin expansion. Sampled only in IDLE.
- key_in  input  128  cipher key. Word w0 = key_in[127:96], w3 = key_in[31:0].
- rk_ready  input  1  consumer accepts `rk_out` this cycle.
- rk_valid  output  1  `rk_out`/`rk_round` hold a valid round key.
- rk_out  output  128  current round key, same word ordering as `key_in`.
- rk_round  output  4  index of the round key on `rk_out` (0..ROUNDS).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse after the final round key is accepted.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state = IDLE, rk_valid = 0, rk_out = 0, rk_round = 0, busy = 0, done = 0
  - internal rcon register = 8'h01.
- All outputs are registered. No combinational path from inputs to outputs.
- State IDLE:
  - start=1 → next edge: rk_out <= key_in, rk_round <= 0, rcon <= 8'h01, rk_valid <= 1, busy <= 1, state <= RUN.
  - start=0 → hold.
- State RUN, transfer = rk_valid & rk_ready:
  - No transfer: rk_out, rk_round, rcon, rk_valid are held stable (stall of any length).
  - Transfer with rk_round < ROUNDS: next edge loads the next key and increments rk_round.
    - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    - RotWord(w) = {w[23:0], w[31:24]}
    - SubWord applies the FIPS-197 forward S-box to each byte, using 4 instances of the team's byte S-box lookup.
    - Next key: w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
    - rcon <= xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
    - The rcon sequence for keys 1..10 is therefore 01,02,04,08,10,20,40,80,1b,36.
  - Transfer with rk_round == ROUNDS: next edge sets rk_valid <= 0, busy <= 0, done <= 1, state <= IDLE. rk_out and rk_round retain the last values.
- done is high for exactly one cycle and then clears.
- Latency: first rk_valid one cycle after start. With rk_ready held at 1, ROUNDS+1 consecutive valid cycles follow.
- start while busy is ignored; the expansion in progress is unaffected.
- start on the same cycle done is high is accepted, because the state is already IDLE.
- Key expansion uses only the registered key. key_in may change after the start cycle.
- Reset asserted mid-expansion aborts immediately to reset values. No done pulse is produced.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start, rk_ready=1 →
  - round 0 = the key
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 2 = f2c295f27a96b9435935807a7359f67f
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - 11 contiguous valid cycles, then one done pulse.
- All-zero key → round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e (checks 1b/36 rcon wrap).
- Random rk_ready toggling on the FIPS key → rk_out/rk_round stable while rk_ready=0. Same 11-key sequence with no skips or repeats.
- start pulsed with a different key during RUN → ignored; the original sequence completes unchanged.
- rst_n pulled low at rk_round=5 → all outputs 0 asynchronously, no done. A fresh start after release restarts from round 0.
- ROUNDS=3 build with the FIPS key → keys 0..3 emitted, done after round 3; round 3 = 3d80477d4716fe3e1e237e446d7a883b.

Source files
------------

// File: rtl/key_expand_seq.sv
// key_expand_seq: iterative AES-128 key schedule. Loads a cipher key on
// start and streams round keys 0..ROUNDS over a valid/ready handshake.
// Also contains aes_sbox, the forward AES byte S-box used for SubWord.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] inv;

  // Inverse followed by the FIPS-197 affine transform
  always_comb begin
    inv      = gf_inv(in_byte);
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

module key_expand_seq #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST = ROUNDS[3:0];

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, valid_d;
  logic         done_q, done_d;

  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  temp_w;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] next_key;

  assign rot_w = {key_q[23:0], key_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*i +: 8]),
      .out_byte (sub_w[8*i +: 8])
    );
  end

  // Next round key derived purely from the registered key and rcon
  always_comb begin
    temp_w   = sub_w ^ {rcon_q, 24'h0};
    w0_n     = key_q[127:96] ^ temp_w;
    w1_n     = key_q[95:64]  ^ w0_n;
    w2_n     = key_q[63:32]  ^ w1_n;
    w3_n     = key_q[31:0]   ^ w2_n;
    next_key = {w0_n, w1_n, w2_n, w3_n};
  end

  // Next-state and datapath update; everything holds unless a transfer occurs
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key_in;
          round_d = '0;
          rcon_d  = 8'h01;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (valid_q && rk_ready) begin
          if (round_q == LAST) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            key_d   = next_key;
            round_d = round_q + 4'd1;
            rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid = valid_q;
  assign rk_out   = key_q;
  assign rk_round = round_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Testbench for key_expand_seq: compares streamed round keys against a
// word-oriented FIPS-197 key-schedule model and published vectors.

module tb_key_expand_seq;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         busy;
  logic         done;

  logic         s3_start;
  logic [127:0] s3_key;
  logic         s3_ready;
  logic         v3;
  logic [127:0] o3;
  logic [3:0]   r3;
  logic         b3;
  logic         d3;

  int total_cnt;
  int pass_cnt;

  logic [7:0]   sbox_tb  [256];
  logic [7:0]   rcon_tab [10];
  logic [127:0] exp_rk   [11];
  logic [127:0] obs      [11];

  key_expand_seq #(.ROUNDS(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  key_expand_seq #(.ROUNDS(3)) dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (s3_start),
    .key_in   (s3_key),
    .rk_ready (s3_ready),
    .rk_valid (v3),
    .rk_out   (o3),
    .rk_round (r3),
    .busy     (b3),
    .done     (d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box built by walking generator 3 and its inverse in lockstep
  task automatic init_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    repeat (255) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tb[p] = x ^ 8'h63;
    end
    sbox_tb[0] = 8'h63;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  // Word-array key expansion w[0..43], grouped into 11 round keys
  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tb[t[31:24]], sbox_tb[t[23:16]], sbox_tb[t[15:8]], sbox_tb[t[7:0]]};
        t = t ^ {rcon_tab[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Full run on the ROUNDS=10 instance, optional random back-pressure and stray start
  task automatic run_seq(input logic [127:0] key, input bit rand_ready, input bit inject);
    int idx;
    int budget;
    bit rdy;
    build_model(key);
    start  = 1'b1;
    key_in = key;
    step();
    start  = 1'b0;
    key_in = rand128();
    idx    = 0;
    budget = 0;
    while (idx <= 10 && budget < 400) begin
      total_cnt++;
      if ({rk_valid, busy, done, rk_round, rk_out} !== {1'b1, 1'b1, 1'b0, 4'(idx), exp_rk[idx]})
        $display("FAIL seq_key idx=%0d: got v=%b b=%b d=%b r=%0d k=%h, want v=1 b=1 d=0 r=%0d k=%h",
                 idx, rk_valid, busy, done, rk_round, rk_out, idx, exp_rk[idx]);
      else pass_cnt++;
      obs[idx] = rk_out;
      rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      start    = inject && (idx == 3);
      if (start) key_in = rand128();
      step();
      budget++;
      if (rdy) idx++;
    end
    start = 1'b0;
    total_cnt++;
    if (idx != 11) $display("FAIL seq_timeout: got %0d keys, want 11", idx);
    else pass_cnt++;
    total_cnt++;
    if ({rk_valid, busy, done, rk_round, rk_out} !== {1'b0, 1'b0, 1'b1, 4'd10, exp_rk[10]})
      $display("FAIL seq_done: got v=%b b=%b d=%b r=%0d k=%h, want v=0 b=0 d=1 r=10 k=%h",
               rk_valid, busy, done, rk_round, rk_out, exp_rk[10]);
    else pass_cnt++;
    rk_ready = 1'b0;
    step();
    total_cnt++;
    if ({rk_valid, busy, done} !== 3'b000)
      $display("FAIL seq_done_clear: got v/b/d=%b%b%b, want 000", rk_valid, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    s3_start = 1'b0; s3_key = '0; s3_ready = 1'b0;
    #1;
    total_cnt++;
    if ({rk_valid, busy, done, rk_round, rk_out} !== '0)
      $display("FAIL reset: got v=%b b=%b d=%b r=%0d k=%h, want all zero", rk_valid, busy, done, rk_round, rk_out);
    else pass_cnt++;
    step(); step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({rk_valid, busy, done} !== 3'b000)
      $display("FAIL reset_idle: got v/b/d=%b%b%b, want 000", rk_valid, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_fips();
    run_seq(FIPS_KEY, 1'b0, 1'b0);
    total_cnt++;
    if ({obs[0], obs[1], obs[2], obs[10]} !== {FIPS_KEY, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6})
      $display("FAIL fips_vectors: got r1=%h r2=%h r10=%h", obs[1], obs[2], obs[10]);
    else pass_cnt++;
  endtask

  task automatic test_zero_key();
    run_seq('0, 1'b0, 1'b0);
    total_cnt++;
    if ({obs[1], obs[10]} !== {128'h62636363626363636263636362636363, 128'hb4ef5bcb3e92e21123e951cf6f8f188e})
      $display("FAIL zero_vectors: got r1=%h r10=%h, want 6263..63 / b4ef..8e", obs[1], obs[10]);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    run_seq(FIPS_KEY, 1'b1, 1'b0);
    run_seq(rand128(), 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_seq(FIPS_KEY, 1'b1, 1'b1);
    total_cnt++;
    if (obs[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
      $display("FAIL start_ignored: got r10=%h, want d014f9a8c9ee2589e13f0cc8b6630ca6", obs[10]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int budget;
    start = 1'b1; key_in = FIPS_KEY;
    step();
    start = 1'b0; rk_ready = 1'b1;
    budget = 0;
    while (rk_round != 4'd5 && budget < 20) begin
      step();
      budget++;
    end
    total_cnt++;
    if (rk_round !== 4'd5) $display("FAIL reset_mid_reach: got round %0d, want 5", rk_round);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rk_valid, busy, done, rk_round, rk_out} !== '0)
      $display("FAIL reset_mid_async: got v=%b b=%b d=%b r=%0d k=%h, want all zero", rk_valid, busy, done, rk_round, rk_out);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (done !== 1'b0) $display("FAIL reset_mid_nodone: got done=%b, want 0", done);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    rk_ready = 1'b0;
    step();
    run_seq(FIPS_KEY, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int budget;
    logic [127:0] k2;
    k2 = rand128();
    start = 1'b1; key_in = FIPS_KEY; rk_ready = 1'b1;
    step();
    start = 1'b0;
    budget = 0;
    while (done !== 1'b1 && budget < 30) begin
      step();
      budget++;
    end
    total_cnt++;
    if (done !== 1'b1) $display("FAIL b2b_done: got done=%b after %0d cycles, want 1", done, budget);
    else pass_cnt++;
    build_model(k2);
    start = 1'b1; key_in = k2;
    step();
    start = 1'b0;
    total_cnt++;
    if ({rk_valid, rk_round, rk_out} !== {1'b1, 4'd0, k2})
      $display("FAIL b2b_restart: got v=%b r=%0d k=%h, want v=1 r=0 k=%h", rk_valid, rk_round, rk_out, k2);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({rk_round, rk_out} !== {4'd1, exp_rk[1]})
      $display("FAIL b2b_round1: got r=%0d k=%h, want r=1 k=%h", rk_round, rk_out, exp_rk[1]);
    else pass_cnt++;
    budget = 0;
    while (done !== 1'b1 && budget < 30) begin
      step();
      budget++;
    end
    total_cnt++;
    if ({done, rk_out} !== {1'b1, exp_rk[10]})
      $display("FAIL b2b_final: got d=%b k=%h, want d=1 k=%h", done, rk_out, exp_rk[10]);
    else pass_cnt++;
    rk_ready = 1'b0;
    step();
  endtask

  task automatic test_rounds3();
    int idx;
    int budget;
    bit rdy;
    build_model(FIPS_KEY);
    s3_start = 1'b1; s3_key = FIPS_KEY;
    step();
    s3_start = 1'b0; s3_key = rand128();
    idx = 0;
    budget = 0;
    while (idx <= 3 && budget < 100) begin
      total_cnt++;
      if ({v3, b3, d3, r3, o3} !== {1'b1, 1'b1, 1'b0, 4'(idx), exp_rk[idx]})
        $display("FAIL r3_key idx=%0d: got v=%b b=%b d=%b r=%0d k=%h, want k=%h", idx, v3, b3, d3, r3, o3, exp_rk[idx]);
      else pass_cnt++;
      rdy = 1'($urandom_range(0, 1));
      s3_ready = rdy;
      step();
      budget++;
      if (rdy) idx++;
    end
    total_cnt++;
    if ({v3, b3, d3, r3, o3} !== {1'b0, 1'b0, 1'b1, 4'd3, 128'h3d80477d4716fe3e1e237e446d7a883b})
      $display("FAIL r3_done: got v=%b b=%b d=%b r=%0d k=%h, want v=0 b=0 d=1 r=3 k=3d80477d4716fe3e1e237e446d7a883b",
               v3, b3, d3, r3, o3);
    else pass_cnt++;
    s3_ready = 1'b0;
    step();
    total_cnt++;
    if ({v3, d3} !== 2'b00) $display("FAIL r3_done_clear: got v/d=%b%b, want 00", v3, d3);
    else pass_cnt++;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    init_tables();
    test_reset();
    test_fips();
    test_zero_key();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_rounds3();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
